// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler.
// The master side is the group of byte producers. The slave side is the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [2:0]                grant_id;
  logic                      busy;
  logic                      tx;

  modport master (
    output req, req_data,
    input  ack, grant_id, busy, tx
  );

  modport slave (
    input  req, req_data,
    output ack, grant_id, busy, tx
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 8N1 UART transmit line among NUM_REQ
// byte producers. Each frame restarts the baud counter at the accept edge.
// Optional feature: define UART_TX_SCHED_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit. This makes the frame 11 bit times long.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_W       = 8
) (
  input logic                clock,
  input logic                reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      PTR_RST  = 3'(NUM_REQ - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_W - 1);

`ifdef UART_TX_SCHED_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [2:0]          rr_q, rr_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [2:0]          gid_q, gid_d;
  logic                busy_q, busy_d;
  logic                tx_q, tx_d;
  logic [DATA_W-1:0]   sh_q;
`ifdef UART_TX_SCHED_PARITY_EN
  logic                par_q;
`endif

  logic                load;
  logic                shift;
  logic                any_req;
  logic [2:0]          win;
  logic [3:0]          cand;
  logic                bit_end;

  assign bit_end      = (cnt_q == CNT_LAST);
  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_q;

  // Round-robin search that starts just after the last winner and wraps modulo NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!any_req && ((bus.req >> cand) & NUM_REQ'(1)) != '0) begin
        any_req = 1'b1;
        win     = cand[2:0];
      end
    end
  end

  // Frame sequencer: next state, baud/bit counters and the registered line/handshake values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rr_d    = rr_q;
    ack_d   = '0;
    gid_d   = gid_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          ack_d   = NUM_REQ'(1) << win;
          gid_d   = win;
          rr_d    = win;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_SCHED_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            shift = 1'b1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control registers. Reset aborts any frame in flight and returns the line to idle-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      rr_q    <= PTR_RST;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register for the character. It is loaded only at accept, so later req_data changes cannot corrupt it.
  always_ff @(posedge clock) begin
    if (load) begin
      sh_q  <= DATA_W'(bus.req_data >> (DATA_W * int'(win)));
`ifdef UART_TX_SCHED_PARITY_EN
      par_q <= ^(DATA_W'(bus.req_data >> (DATA_W * int'(win))));
`endif
    end else if (shift) begin
      sh_q <= sh_q >> 1;
    end
  end

endmodule
